// File: rtl/lpc_cycle_fifo.sv
// Filters completed LPC cycle records by address window and cycle type and buffers the accepted
// ones in a first-word-fall-through FIFO with a valid/ready output and drop statistics.
module lpc_cycle_fifo #(
    parameter int unsigned DEPTH         = 16,
    parameter logic [15:0] ADDR_LO       = 16'h0080,
    parameter logic [15:0] ADDR_HI       = 16'h0080,
    parameter bit          CAPTURE_READS = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       nrst_i,
    input  logic [31:0]                tdata_i,
    input  logic                       ready_i,
    input  logic                       filter_en_i,
    input  logic                       clear_i,
    output logic [31:0]                m_data_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FullLevel = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LvlOne    = 1;
    localparam logic [AW-1:0] PtrOne    = 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ready_q;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic          rec_event, in_window, type_ok, accept, full, pop, push, drop;

    always_comb begin
        rec_event = ready_i & ~ready_q;
        in_window = (tdata_i[31:16] >= ADDR_LO) && (tdata_i[31:16] <= ADDR_HI);
        type_ok   = (tdata_i[7:0] == 8'h01) || ((tdata_i[7:0] == 8'h00) && CAPTURE_READS);
        accept    = rec_event && (!filter_en_i || (in_window && type_ok));
        full      = (level_q == FullLevel);
        pop       = (level_q != '0) && m_ready_i;
        // A full FIFO still takes the record when the head leaves on the same edge.
        push      = accept && (!full || pop) && !clear_i;
        drop      = accept && full && !pop && !clear_i;
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            wptr_d     = '0;
            rptr_d     = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PtrOne;
            if (pop)  rptr_d = rptr_q + PtrOne;
            unique case ({push, pop})
                2'b10:   level_d = level_q + LvlOne;
                2'b01:   level_d = level_q - LvlOne;
                default: level_d = level_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            ready_q    <= ready_i;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset; the head is masked to zero while empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= tdata_i;
    end

    assign m_valid_o  = (level_q != '0);
    assign m_data_o   = m_valid_o ? mem_q[rptr_q] : 32'h0;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_lpc_cycle_fifo.sv
// Directed bench for lpc_cycle_fifo with default parameters (DEPTH 16, window 0x0080, writes only).
module tb_lpc_cycle_fifo;

    logic        clk_i = 1'b0;
    logic        nrst_i = 1'b0;
    logic [31:0] tdata_i = 32'h0;
    logic        ready_i = 1'b0;
    logic        filter_en_i = 1'b1;
    logic        clear_i = 1'b0;
    logic [31:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b0;
    logic [4:0]  level_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;

    int total = 0;
    int bad = 0;

    lpc_cycle_fifo dut (
        .clk_i       (clk_i),
        .nrst_i      (nrst_i),
        .tdata_i     (tdata_i),
        .ready_i     (ready_i),
        .filter_en_i (filter_en_i),
        .clear_i     (clear_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .level_o     (level_o),
        .overflow_o  (overflow_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One record: ready high for one edge, then low for one edge.
    task automatic send(input logic [31:0] d);
        tdata_i = d;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        nrst_i = 1'b0;
        tick();
        total++; if (level_o !== 5'd0)      begin bad++; $display("FAIL reset_level got=%0d want=0", level_o); end
        total++; if (m_valid_o !== 1'b0)    begin bad++; $display("FAIL reset_valid got=%b want=0", m_valid_o); end
        total++; if (m_data_o !== 32'h0)    begin bad++; $display("FAIL reset_data got=%h want=0", m_data_o); end
        total++; if (overflow_o !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow_o); end
        total++; if (drop_cnt_o !== 16'h0)  begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt_o); end
        nrst_i = 1'b1;
        tick();
    endtask

    task automatic test_single_event();
        filter_en_i = 1'b1;
        tdata_i = 32'h0080_5A01;
        ready_i = 1'b1;
        tick();
        total++; if (m_valid_o !== 1'b1)        begin bad++; $display("FAIL single_valid got=%b want=1", m_valid_o); end
        total++; if (m_data_o !== 32'h0080_5A01) begin bad++; $display("FAIL single_data got=%h want=00805a01", m_data_o); end
        tick();
        tick();
        ready_i = 1'b0;
        tick();
        total++; if (level_o !== 5'd1)          begin bad++; $display("FAIL single_level got=%0d want=1", level_o); end
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        total++; if (m_valid_o !== 1'b0)        begin bad++; $display("FAIL single_drain got=%b want=0", m_valid_o); end
    endtask

    task automatic test_filter();
        filter_en_i = 1'b1;
        send(32'h0080_1101);
        send(32'h0080_2200);
        send(32'h0081_3301);
        send(32'h0080_4402);
        send(32'h007F_5501);
        total++; if (level_o !== 5'd1)           begin bad++; $display("FAIL filter_level got=%0d want=1", level_o); end
        total++; if (m_data_o !== 32'h0080_1101) begin bad++; $display("FAIL filter_data got=%h want=00801101", m_data_o); end
        total++; if (drop_cnt_o !== 16'd0)       begin bad++; $display("FAIL filter_drop got=%0d want=0", drop_cnt_o); end
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
    endtask

    task automatic test_overflow();
        filter_en_i = 1'b0;
        for (int i = 0; i < 20; i++) send(32'(i));
        total++; if (level_o !== 5'd16)     begin bad++; $display("FAIL ovf_level got=%0d want=16", level_o); end
        total++; if (overflow_o !== 1'b1)   begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow_o); end
        total++; if (drop_cnt_o !== 16'd4)  begin bad++; $display("FAIL ovf_drop got=%0d want=4", drop_cnt_o); end
        m_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (m_data_o !== 32'(i)) begin bad++; $display("FAIL drain_%0d got=%h want=%h", i, m_data_o, 32'(i)); end
            tick();
        end
        m_ready_i = 1'b0;
        total++; if (m_valid_o !== 1'b0)    begin bad++; $display("FAIL drain_empty got=%b want=0", m_valid_o); end
        total++; if (level_o !== 5'd0)      begin bad++; $display("FAIL drain_level got=%0d want=0", level_o); end
    endtask

    task automatic test_full_push_pop();
        filter_en_i = 1'b0;
        for (int i = 0; i < 16; i++) send(32'(100 + i));
        total++; if (level_o !== 5'd16)     begin bad++; $display("FAIL fpp_fill got=%0d want=16", level_o); end
        tdata_i = 32'd200;
        ready_i = 1'b1;
        m_ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        m_ready_i = 1'b0;
        total++; if (level_o !== 5'd16)     begin bad++; $display("FAIL fpp_level got=%0d want=16", level_o); end
        total++; if (drop_cnt_o !== 16'd4)  begin bad++; $display("FAIL fpp_drop got=%0d want=4", drop_cnt_o); end
        total++; if (m_data_o !== 32'd101)  begin bad++; $display("FAIL fpp_head got=%0d want=101", m_data_o); end
        tick();
        // Head must hold while not accepted.
        total++; if (m_data_o !== 32'd101)  begin bad++; $display("FAIL fpp_hold got=%0d want=101", m_data_o); end
    endtask

    task automatic test_clear();
        m_ready_i = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        m_ready_i = 1'b0;
        total++; if (level_o !== 5'd5)      begin bad++; $display("FAIL clr_pre_level got=%0d want=5", level_o); end
        total++; if (overflow_o !== 1'b1)   begin bad++; $display("FAIL clr_pre_ovf got=%b want=1", overflow_o); end
        tdata_i = 32'h0080_7701;
        ready_i = 1'b1;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        total++; if (level_o !== 5'd0)      begin bad++; $display("FAIL clr_level got=%0d want=0", level_o); end
        total++; if (m_valid_o !== 1'b0)    begin bad++; $display("FAIL clr_valid got=%b want=0", m_valid_o); end
        total++; if (overflow_o !== 1'b0)   begin bad++; $display("FAIL clr_ovf got=%b want=0", overflow_o); end
        total++; if (drop_cnt_o !== 16'd0)  begin bad++; $display("FAIL clr_drop got=%0d want=0", drop_cnt_o); end
        tick();
        ready_i = 1'b0;
        total++; if (level_o !== 5'd0)      begin bad++; $display("FAIL clr_no_reevent got=%0d want=0", level_o); end
        tick();
    endtask

    task automatic test_empty_ready();
        m_ready_i = 1'b1;
        tdata_i = 32'h0000_0ABC;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        total++; if (level_o !== 5'd1)      begin bad++; $display("FAIL empty_rdy_level got=%0d want=1", level_o); end
        total++; if (m_data_o !== 32'h0ABC) begin bad++; $display("FAIL empty_rdy_data got=%h want=00000abc", m_data_o); end
        tick();
        m_ready_i = 1'b0;
        total++; if (level_o !== 5'd0)      begin bad++; $display("FAIL empty_rdy_pop got=%0d want=0", level_o); end
    endtask

    task automatic test_reset_mid();
        filter_en_i = 1'b0;
        send(32'd1);
        send(32'd2);
        send(32'd3);
        total++; if (level_o !== 5'd3)      begin bad++; $display("FAIL rst_pre_level got=%0d want=3", level_o); end
        #2;
        nrst_i = 1'b0;
        #1;
        total++; if (level_o !== 5'd0)      begin bad++; $display("FAIL rst_async_level got=%0d want=0", level_o); end
        total++; if (m_valid_o !== 1'b0)    begin bad++; $display("FAIL rst_async_valid got=%b want=0", m_valid_o); end
        total++; if (m_data_o !== 32'h0)    begin bad++; $display("FAIL rst_async_data got=%h want=0", m_data_o); end
        tick();
        nrst_i = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            tdata_i = 32'(500 + i);
            ready_i = 1'b1;
            tick();
            ready_i = 1'b0;
            total++;
            if (level_o !== 5'd1 || m_data_o !== 32'(500 + i)) begin
                bad++;
                $display("FAIL wrap_push_%0d got=%0d/%0d want=1/%0d", i, level_o, m_data_o, 500 + i);
            end
            m_ready_i = 1'b1;
            tick();
            m_ready_i = 1'b0;
        end
        total++; if (level_o !== 5'd0)      begin bad++; $display("FAIL wrap_end_level got=%0d want=0", level_o); end
    endtask

    task automatic test_reset_ready_high();
        nrst_i = 1'b0;
        tdata_i = 32'h0000_0D0D;
        ready_i = 1'b1;
        tick();
        nrst_i = 1'b1;
        tick();
        total++; if (level_o !== 5'd1)      begin bad++; $display("FAIL rel_event_level got=%0d want=1", level_o); end
        tick();
        ready_i = 1'b0;
        total++; if (level_o !== 5'd1)      begin bad++; $display("FAIL rel_single got=%0d want=1", level_o); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_filter();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_empty_ready();
        test_reset_mid();
        test_reset_ready_high();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
